// File: rtl/reg_file_param.sv
// rtl/reg_file_param.sv - parametrised 2R/1W register file with bypass, pending scoreboard and zero-fill sweep
module reg_file_param #(
  parameter int DATA_W   = 16,
  parameter int ADDR_W   = 4,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic              clk,
  input  logic              clear,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [ADDR_W-1:0] b_addr,
  output logic [DATA_W-1:0] a_data,
  output logic [DATA_W-1:0] b_data,
  output logic              a_pend,
  output logic              b_pend,
  input  logic [ADDR_W-1:0] c_addr,
  input  logic [DATA_W-1:0] c_data,
  input  logic              load,
  input  logic              rsv,
  input  logic [ADDR_W-1:0] rsv_addr,
  input  logic              sweep_start,
  output logic              sweep_busy,
  output logic              sweep_done
);

  localparam int DEPTH = 1 << ADDR_W;
  // Register 0 is hardwired when ZERO_REG is set, so the sweep skips it.
  localparam logic [ADDR_W-1:0] START = (ZERO_REG != 0) ? ADDR_W'(1) : '0;
  localparam logic [ADDR_W-1:0] LAST  = ADDR_W'(DEPTH - 1);

  typedef enum logic {IDLE, SWEEP} state_t;

  state_t            state, state_n;
  logic [ADDR_W-1:0] idx, idx_n;
  logic              done_n;
  logic              sweep_wr;
  logic [DATA_W-1:0] regs [DEPTH];
  logic [DEPTH-1:0]  pend;
  logic              a_hit, b_hit;

  function automatic logic is_zero(input logic [ADDR_W-1:0] addr);
    return (ZERO_REG != 0) && (addr == '0);
  endfunction

  // Sweep FSM state, index and the registered done pulse.
  always_ff @(posedge clk) begin
    if (clear) begin
      state      <= IDLE;
      idx        <= '0;
      sweep_done <= 1'b0;
    end else begin
      state      <= state_n;
      idx        <= idx_n;
      sweep_done <= done_n;
    end
  end

  // Sweep next-state: walk idx from START up to LAST, one register per cycle, no wrap.
  always_comb begin
    state_n  = state;
    idx_n    = idx;
    done_n   = 1'b0;
    sweep_wr = 1'b0;
    case (state)
      IDLE: begin
        if (sweep_start) begin
          state_n = SWEEP;
          idx_n   = START;
        end
      end
      SWEEP: begin
        sweep_wr = 1'b1;
        if (idx == LAST) begin
          state_n = IDLE;
          done_n  = 1'b1;
        end else begin
          idx_n = idx + ADDR_W'(1);
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign sweep_busy = (state == SWEEP);

  // Storage and pending bits: writeback beats the sweep, reserve beats both for pend.
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (clear || is_zero(ADDR_W'(i))) begin
        regs[i] <= '0;
        pend[i] <= 1'b0;
      end else begin
        if (load && c_addr == ADDR_W'(i))
          regs[i] <= c_data;
        else if (sweep_wr && idx == ADDR_W'(i))
          regs[i] <= '0;

        if (rsv && rsv_addr == ADDR_W'(i))
          pend[i] <= 1'b1;
        else if ((load && c_addr == ADDR_W'(i)) || (sweep_wr && idx == ADDR_W'(i)))
          pend[i] <= 1'b0;
      end
    end
  end

  // Read ports: a same-cycle writeback to the read address is forwarded and hides pend.
  always_comb begin
    a_hit  = (BYPASS != 0) && load && (c_addr == a_addr) && !is_zero(c_addr);
    b_hit  = (BYPASS != 0) && load && (c_addr == b_addr) && !is_zero(c_addr);
    a_data = is_zero(a_addr) ? '0 : (a_hit ? c_data : regs[a_addr]);
    b_data = is_zero(b_addr) ? '0 : (b_hit ? c_data : regs[b_addr]);
    a_pend = !is_zero(a_addr) && pend[a_addr] && !a_hit;
    b_pend = !is_zero(b_addr) && pend[b_addr] && !b_hit;
  end

endmodule
